multich_ll_detector: RTL
========================

# multich_ll_detector

Multi-channel line-length seizure detector and stimulation trigger: a parametrised successor to the single-stream datapath. It sits between the time-multiplexed iEEG sample stream and the stimulator. It computes per-channel windowed line length, requires a configurable number of consecutive over-threshold windows, and fires a fixed-length stimulation pulse with an optional refractory period.

## Interface
- DATA_WIDTH, 16: signed sample width.
- CHANNELS, 4: interleaved channels, ≥1; CH_W = max(1, clog2(CHANNELS)).
- WIN_LOG2, 8: window length = 2^WIN_LOG2 samples per channel.
- LL_OUTPUT_WIDTH, DATA_WIDTH+1+WIN_LOG2 (25): accumulator width. Overflow is impossible by construction.
- HOLD_WINDOWS, 3: consecutive over-threshold windows before a channel is flagged, ≥1.
- MIN_CH, 1: flagged channels needed to trigger, 1..CHANNELS.
- STIM_CYCLES, 1000: stimulation pulse length in clocks, ≥1.
- REFRACT_CYCLES, 5000: refractory length in clocks, ≥1. Used only with the macro.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset. Has priority over everything.
- en  in  1  sample strobe: din is one sample of the current channel.
- din  in  DATA_WIDTH  signed sample, round-robin channel order 0..CHANNELS-1.
- thresh  in  LL_OUTPUT_WIDTH  unsigned line-length threshold.
- ll_out  out  LL_OUTPUT_WIDTH  completed window line length.
- ll_valid  out  1  one-cycle pulse when ll_out/ll_ch are valid.
- ll_ch  out  CH_W  channel of ll_out.
- det_mask  out  CHANNELS  per-channel flag: hold counter ≥ HOLD_WINDOWS.
- stimulation  out  1  stimulation request.

## Operation
- Internal channel pointer ch_idx advances on each en-high cycle and wraps after CHANNELS-1. Window sample counter increments when a channel CHANNELS-1 sample is accepted.
- Per channel, keep prev sample, primed bit and accumulator.
- First accepted sample after reset: primes prev and adds 0.
- Each later sample adds |din − prev| (computed at DATA_WIDTH+1 bits, max 65535 at 16 bits), then prev ← din.
- prev carries across window boundaries.
- Last sample of a window for channel c: ll_out = accumulator including that sample, ll_ch = c, ll_valid = 1. Accumulator restarts at 0.
- At each ll_valid, update channel c's hold counter: if ll_out > thresh (strict, unsigned), increment and saturate at HOLD_WINDOWS; otherwise clear to 0. det_mask[c] reflects the updated counter.
- FSM states: IDLE, STIM, REFRACT.
  - IDLE→STIM when ll_valid && ll_ch == CHANNELS-1 && popcount(det_mask, updated) ≥ MIN_CH.
  - STIM holds exactly STIM_CYCLES cycles, then →REFRACT. Triggers are ignored during STIM (non-retriggerable).
  - REFRACT holds REFRACT_CYCLES cycles, ignores triggers, then →IDLE.
- stimulation = (state == STIM).
- FSM timers run every clock, independent of en. Detection continues in all states.

## Timing
- Reset values: ll_out 0, ll_valid 0, ll_ch 0, det_mask 0, stimulation 0. All state cleared, ch_idx 0, window counter 0, all channels unprimed, FSM IDLE.
- ll_valid, ll_out, ll_ch and det_mask are registered: valid the cycle after the last window sample's en cycle.
- stimulation rises the cycle after the triggering ll_valid cycle (2 cycles after the final sample), then stays high exactly STIM_CYCLES cycles.
- en low: no state change except FSM timers. Gaps of any length do not alter results.
- rst mid-window or mid-STIM: stimulation is 0 on the next cycle. The partial window is discarded and the next sample is treated as channel 0, unprimed.
- A threshold change takes effect at the next comparison.

## Configuration
- LL_REFRACTORY_EN defined: REFRACT state and REFRACT_CYCLES are active, as described above.
- LL_REFRACTORY_EN undefined: STIM→IDLE directly. A qualifying window end in the first IDLE cycle or later retriggers. No refractory counter is synthesised.

## Test plan
Bench parameters: CHANNELS=2, WIN_LOG2=2, HOLD_WINDOWS=2, MIN_CH=1, STIM_CYCLES=5, REFRACT_CYCLES=10.
- Reset plus constant din=100 on both channels for 4 windows -> all ll_out=0, det_mask=0, stimulation=0. Outputs are 0 during rst.
- ch0 samples 0,10,-10,20, ch1 samples 32767,-32768,0,0 (interleaved) -> ll_out 60 with ll_ch=0, then 98303 with ll_ch=1. Next ch0 sample 20 adds 0 (prev carried).
- thresh=50, ch0 gives 60 for two windows, ch1 is quiet -> det_mask=01 after the second ch0 ll_valid. stimulation rises one cycle after the second ll_ch=1 ll_valid and stays high 5 cycles.
- Sustained over-threshold input with macro defined -> no retrigger during 10 refractory cycles; first retrigger at the next qualifying window end afterwards. Macro undefined -> retrigger at the first qualifying window end after stim falls.
- en toggling 1,0,0,1,… versus en held high -> identical ll_out/ll_ch sequence.
- rst pulse mid-STIM and mid-window -> stimulation 0 the next cycle. The first subsequent sample primes channel 0 and contributes 0.

Source files
------------

// File: rtl/multich_ll_detector.sv
// Multi-channel windowed line-length detector driving a fixed-length stimulation pulse.
// Define LL_REFRACTORY_EN to add a refractory period after each pulse.
module multich_ll_detector #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned WIN_LOG2        = 8,
    parameter int unsigned LL_OUTPUT_WIDTH = DATA_WIDTH + 1 + WIN_LOG2,
    parameter int unsigned HOLD_WINDOWS    = 3,
    parameter int unsigned MIN_CH          = 1,
    parameter int unsigned STIM_CYCLES     = 1000,
    parameter int unsigned REFRACT_CYCLES  = 5000,
    localparam int unsigned CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic [LL_OUTPUT_WIDTH-1:0]  thresh,
    output logic [LL_OUTPUT_WIDTH-1:0]  ll_out,
    output logic                        ll_valid,
    output logic [CH_W-1:0]             ll_ch,
    output logic [CHANNELS-1:0]         det_mask,
    output logic                        stimulation
);

    localparam int unsigned DW1  = DATA_WIDTH + 1;
    localparam int unsigned LL_W = LL_OUTPUT_WIDTH;
    localparam int unsigned HC_W = $clog2(HOLD_WINDOWS + 1);
    localparam int unsigned CNT_W = CH_W + 1;
`ifdef LL_REFRACTORY_EN
    localparam int unsigned TMR_MAX = (STIM_CYCLES > REFRACT_CYCLES) ? STIM_CYCLES : REFRACT_CYCLES;
`else
    localparam int unsigned TMR_MAX = STIM_CYCLES;
`endif
    localparam int unsigned TMR_W = $clog2(TMR_MAX + 1);

    localparam logic [CH_W-1:0]     LAST_CH  = CH_W'(CHANNELS - 1);
    localparam logic [WIN_LOG2-1:0] LAST_WIN = '1;
    localparam logic [HC_W-1:0]     HOLD_MAX = HC_W'(HOLD_WINDOWS);

    // An out-of-range configuration never fires the stimulator.
    localparam bit CFG_OK = (CHANNELS >= 1) && (HOLD_WINDOWS >= 1) && (MIN_CH >= 1) &&
                            (MIN_CH <= CHANNELS) && (STIM_CYCLES >= 1) && (REFRACT_CYCLES >= 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STIM    = 2'd1,
        REFRACT = 2'd2
    } state_t;

    logic [CH_W-1:0]               ch_idx;
    logic [WIN_LOG2-1:0]           win_cnt;
    logic signed [DATA_WIDTH-1:0]  prev [CHANNELS];
    logic [CHANNELS-1:0]           primed;
    logic [LL_W-1:0]               acc  [CHANNELS];
    logic [HC_W-1:0]               hold [CHANNELS];

    logic signed [DW1-1:0]         diff;
    logic [DW1-1:0]                abs_diff;
    logic [LL_W-1:0]               sum;
    logic                          win_end;
    logic [HC_W-1:0]               hold_upd;

    state_t                        state, state_nx;
    logic [TMR_W-1:0]              tmr, tmr_nx;
    logic [CNT_W-1:0]              n_det;
    logic                          trig;

    // Line-length increment for the sample currently on din.
    always_comb begin
        diff     = DW1'($signed(din)) - DW1'(prev[ch_idx]);
        abs_diff = diff[DW1-1] ? $unsigned(-diff) : $unsigned(diff);
        sum      = acc[ch_idx] + (primed[ch_idx] ? LL_W'(abs_diff) : '0);
        win_end  = en && (win_cnt == LAST_WIN);
        if (sum > thresh) begin
            hold_upd = (hold[ch_idx] == HOLD_MAX) ? hold[ch_idx] : hold[ch_idx] + HC_W'(1);
        end else begin
            hold_upd = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_idx   <= '0;
            win_cnt  <= '0;
            primed   <= '0;
            ll_out   <= '0;
            ll_valid <= 1'b0;
            ll_ch    <= '0;
            det_mask <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                prev[i] <= '0;
                acc[i]  <= '0;
                hold[i] <= '0;
            end
        end else begin
            ll_valid <= win_end;
            if (en) begin
                prev[ch_idx]   <= $signed(din);
                primed[ch_idx] <= 1'b1;
                acc[ch_idx]    <= win_end ? '0 : sum;
                if (ch_idx == LAST_CH) begin
                    ch_idx  <= '0;
                    win_cnt <= win_cnt + WIN_LOG2'(1);
                end else begin
                    ch_idx <= ch_idx + CH_W'(1);
                end
            end
            if (win_end) begin
                ll_out           <= sum;
                ll_ch            <= ch_idx;
                hold[ch_idx]     <= hold_upd;
                det_mask[ch_idx] <= (hold_upd == HOLD_MAX);
            end
        end
    end

    // Trigger is qualified on the registered, already-updated detection mask.
    always_comb begin
        n_det = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            n_det = n_det + CNT_W'(det_mask[i]);
        end
        trig = CFG_OK && ll_valid && (ll_ch == LAST_CH) && (n_det >= CNT_W'(MIN_CH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nx;
            tmr   <= tmr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        case (state)
            IDLE: begin
                if (trig) begin
                    state_nx = STIM;
                    tmr_nx   = '0;
                end
            end
            STIM: begin
                if (tmr == TMR_W'(STIM_CYCLES - 1)) begin
`ifdef LL_REFRACTORY_EN
                    state_nx = REFRACT;
`else
                    state_nx = IDLE;
`endif
                    tmr_nx   = '0;
                end else begin
                    tmr_nx = tmr + TMR_W'(1);
                end
            end
            REFRACT: begin
`ifdef LL_REFRACTORY_EN
                if (tmr == TMR_W'(REFRACT_CYCLES - 1)) begin
                    state_nx = IDLE;
                    tmr_nx   = '0;
                end else begin
                    tmr_nx = tmr + TMR_W'(1);
                end
`else
                state_nx = IDLE;
                tmr_nx   = '0;
`endif
            end
            default: begin
                state_nx = IDLE;
                tmr_nx   = '0;
            end
        endcase
    end

    assign stimulation = (state == STIM);

endmodule
